// File: rtl/wb_arb_pkg.sv
// Shared types and default widths for the Wishbone master arbiter.
// The SPI command scheduler can reuse these as well.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BUSY  = 2'd1,
        ARB_ABORT = 2'd2
    } arb_state_e;

    localparam int WB_ADR_W = 26;
    localparam int WB_DAT_W = 32;

endpackage

// File: rtl/wb_master_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot winner is the first requester at or after ptr+1 (mod N).
// Holds no state, so the SPI command scheduler can reuse it as-is.
module rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     winner
);

    int idx;

    // NOTE: every output gets a default before the loop, so no latch can be inferred.
    always_comb begin
        winner = '0;
        idx    = 0;
        // Walk from the farthest candidate to the nearest; the nearest requester overwrites the rest.
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                winner      = '0;
                winner[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter that shares one Wishbone classic bus among N_MASTERS masters.
// A watchdog aborts transfers that never get an ack, so a silent slave cannot hang the bus.
module wb_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADR_W     = WB_ADR_W,
    parameter int DAT_W     = WB_DAT_W,
    parameter int TIMEOUT   = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_MASTERS-1:0]       m_cyc,
    input  logic [N_MASTERS-1:0]       m_stb,
    input  logic [N_MASTERS-1:0]       m_we,
    input  logic [N_MASTERS*ADR_W-1:0] m_adr,
    input  logic [N_MASTERS*DAT_W-1:0] m_dat,
    output logic [N_MASTERS-1:0]       m_ack,
    output logic [N_MASTERS-1:0]       m_err,
    output logic [DAT_W-1:0]           m_rdat,
    output logic                       s_cyc,
    output logic                       s_stb,
    output logic                       s_we,
    output logic [ADR_W-1:0]           s_adr,
    output logic [DAT_W-1:0]           s_dat,
    input  logic                       s_ack,
    input  logic [DAT_W-1:0]           s_rdat,
    output logic [N_MASTERS-1:0]       grant,
    output logic [7:0]                 timeout_cnt
);

    localparam int          PTR_W   = $clog2(N_MASTERS);
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    arb_state_e           state;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     g_idx;
    logic [15:0]          wd;
    logic [N_MASTERS-1:0] winner;
    logic [PTR_W-1:0]     win_idx;
    logic                 busy;

    rr_pick #(
        .N     (N_MASTERS),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (m_cyc),
        .ptr    (ptr),
        .winner (winner)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (winner[i]) win_idx = PTR_W'(i);
        end
    end

    // The slave side follows the owner combinationally, so the owner dropping cyc releases the bus at once.
    assign busy   = (state == ARB_BUSY);
    assign s_cyc  = busy & m_cyc[g_idx];
    assign s_stb  = busy & m_stb[g_idx];
    assign s_we   = busy & m_we[g_idx];
    assign s_adr  = m_adr[int'(g_idx)*ADR_W +: ADR_W];
    assign s_dat  = m_dat[int'(g_idx)*DAT_W +: DAT_W];
    assign m_ack  = grant & {N_MASTERS{s_ack & s_cyc}};
    assign m_rdat = s_rdat;

    // NOTE: all state updates use non-blocking assignments, so each branch reads pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            grant       <= '0;
            g_idx       <= '0;
            ptr         <= '0;
            wd          <= '0;
            m_err       <= '0;
            timeout_cnt <= '0;
        end else begin
            m_err <= '0;
            case (state)
                ARB_IDLE: begin
                    wd <= '0;
                    if (|m_cyc) begin
                        grant <= winner;
                        g_idx <= win_idx;
                        state <= ARB_BUSY;
                    end
                end

                ARB_BUSY: begin
                    if (!s_cyc) begin
                        grant <= '0;
                        ptr   <= g_idx;
                        wd    <= '0;
                        state <= ARB_IDLE;
                    end else if (s_ack) begin
                        wd <= '0;
                    end else if (wd == WD_LAST) begin
                        wd    <= '0;
                        m_err <= grant;
                        if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
                        state <= ARB_ABORT;
                    end else begin
                        wd <= wd + 16'd1;
                    end
                end

                // Keep the bus parked on the aborted owner until it lets go of cyc.
                ARB_ABORT: begin
                    if (!m_cyc[g_idx]) begin
                        grant <= '0;
                        ptr   <= g_idx;
                        state <= ARB_IDLE;
                    end
                end

                default: begin
                    grant <= '0;
                    wd    <= '0;
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
